// File: rtl/rf_pkg.sv
// rf_pkg -- shared constants and helpers for the multi-port register file.
//
// Contents:
//   DATA_W_DEF    default register width
//   NUM_REGS_DEF  default number of architectural registers
//   REG_ZERO      index of the hard-wired zero register
//   POP_MAX_W     widest vector rf_popcount accepts (callers zero-extend)
//   rf_popcount   population count, used for the pending-register counter
package rf_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int REG_ZERO     = 0;
  localparam int POP_MAX_W    = 256;

  // Counts the set bits of a vector. Narrower vectors are zero-extended by the
  // caller so the function has a single fixed signature.
  function automatic int unsigned rf_popcount(input logic [POP_MAX_W-1:0] vec);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      n += {31'd0, vec[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/rf_bypass_mux.sv
// rf_bypass_mux -- write-to-read forwarding for one read port.
//
// Ports:
//   rd_addr      read address of this port
//   stored_data  value currently held in the array for rd_addr
//   wr_valid     per write port: write will really commit this cycle
//                (enabled, nonzero, in range, not in reset)
//   wr_addr      all write addresses, port j at [j*ADDR_W +: ADDR_W]
//   wr_data      all write data, port j at [j*DATA_W +: DATA_W]
//   fwd_data     stored_data, or the data of the highest-index matching write
//   hit          1 when some committing write targets rd_addr
module rf_bypass_mux
  import rf_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_WR = 2
) (
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic [DATA_W-1:0]        stored_data,
  input  logic [NUM_WR-1:0]        wr_valid,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0]        fwd_data,
  output logic                     hit
);

  // Ports are scanned in ascending order so a later (higher-index) match
  // overrides an earlier one, mirroring the commit priority of the array.
  always_comb begin
    fwd_data = stored_data;
    hit      = 1'b0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_valid[j] &&
          (wr_addr[j*ADDR_W +: ADDR_W] == rd_addr) &&
          (rd_addr != ADDR_W'(REG_ZERO))) begin
        fwd_data = wr_data[j*DATA_W +: DATA_W];
        hit      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp -- parametrised multi-port register file with pending scoreboard.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset (clears data and pending bits)
//   rd_addr        NUM_RD read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data        NUM_RD combinational read data, port i at [i*DATA_W +: DATA_W]
//   rd_pending     per read port: addressed register awaits a write
//   wr_en          per write port enable
//   wr_addr        NUM_WR write addresses
//   wr_data        NUM_WR write data
//   pend_set_en    mark pend_set_addr as pending at the next edge
//   pend_set_addr  register to mark
//   pend_cnt       registered number of pending registers
//
// Register 0 reads as zero and never becomes pending. Addresses at or above
// NUM_REGS are ignored for writes/sets and read as zero, not pending.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     pend_set_en,
  input  logic [ADDR_W-1:0]        pend_set_addr,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam int              CNT_W      = ADDR_W + 1;
  localparam logic [ADDR_W:0] NUM_REGS_L = CNT_W'(NUM_REGS);
  localparam logic            BYP_EN     = (BYPASS != 0);

  logic [DATA_W-1:0]    regs [NUM_REGS];
  logic [NUM_REGS-1:0]  pending;
  logic [NUM_REGS-1:0]  pend_next;
  logic [POP_MAX_W-1:0] pop_ext;
  logic [NUM_WR-1:0]    wr_valid;
  logic                 set_valid;

  // A write or set only takes effect for a real register other than r0, and
  // never while reset is held; gating with rst_n here also keeps forwarded
  // data off rd_data during reset.
  always_comb begin
    wr_valid = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      wr_valid[j] = wr_en[j] && rst_n &&
                    (wr_addr[j*ADDR_W +: ADDR_W] != ADDR_W'(REG_ZERO)) &&
                    ({1'b0, wr_addr[j*ADDR_W +: ADDR_W]} < NUM_REGS_L);
    end
    set_valid = pend_set_en && rst_n &&
                (pend_set_addr != ADDR_W'(REG_ZERO)) &&
                ({1'b0, pend_set_addr} < NUM_REGS_L);
  end

  // Register array. Ports are applied in ascending order so the last
  // non-blocking assignment, from the highest-index port, wins a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_valid[j]) begin
          regs[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Next pending vector: writes clear first, then a set is applied on top so
  // a newly issued producer keeps the register pending.
  always_comb begin
    pend_next = pending;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_valid[j]) begin
        pend_next[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (set_valid) begin
      pend_next[pend_set_addr] = 1'b1;
    end
    pop_ext = '0;
    pop_ext[NUM_REGS-1:0] = pend_next;
  end

  // Counting the next vector keeps pend_cnt in step with the pending bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      pending  <= pend_next;
      pend_cnt <= CNT_W'(rf_popcount(pop_ext));
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              ra_ok;
    logic [DATA_W-1:0] stored;
    logic              stored_pend;
    logic [DATA_W-1:0] fwd;
    logic              hit;

    assign ra          = rd_addr[i*ADDR_W +: ADDR_W];
    assign ra_ok       = (ra != ADDR_W'(REG_ZERO)) && ({1'b0, ra} < NUM_REGS_L);
    assign stored      = ra_ok ? regs[ra] : '0;
    assign stored_pend = ra_ok ? pending[ra] : 1'b0;

    rf_bypass_mux #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_WR (NUM_WR)
    ) u_bypass (
      .rd_addr     (ra),
      .stored_data (stored),
      .wr_valid    (wr_valid),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .fwd_data    (fwd),
      .hit         (hit)
    );

    // With forwarding, a same-cycle write both supplies the data and retires
    // the pending state the reader would otherwise see.
    assign rd_data[i*DATA_W +: DATA_W] = BYP_EN ? fwd : stored;
    assign rd_pending[i]               = stored_pend & ~(BYP_EN & hit);
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp -- self-checking bench for regfile_mp.
//
// Two instances share all inputs: one with forwarding (BYPASS=1) and one
// without (BYPASS=0). A behavioural model of the architectural state is kept
// in plain arrays and every falling edge both instances are compared against
// it. Directed sequences add hand-computed literal expectations, followed by
// randomized traffic with occasional mid-run resets.
module tb_regfile_mp;
  import rf_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        pend_set_en;
  logic [4:0]  pend_set_addr;

  logic [63:0] rd_data_b,  rd_data_n;
  logic [1:0]  rd_pend_b,  rd_pend_n;
  logic [5:0]  cnt_b,      cnt_n;

  int checks;
  int errors;
  bit check_en;

  logic [31:0] m_mem  [32];
  bit          m_pend [32];

  logic [POP_MAX_W-1:0] pc_vec;

  regfile_mp #(.BYPASS(1)) dut_b (
    .clk           (clk),
    .rst_n         (rst_n),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data_b),
    .rd_pending    (rd_pend_b),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .pend_set_en   (pend_set_en),
    .pend_set_addr (pend_set_addr),
    .pend_cnt      (cnt_b)
  );

  regfile_mp #(.BYPASS(0)) dut_n (
    .clk           (clk),
    .rst_n         (rst_n),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data_n),
    .rd_pending    (rd_pend_n),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .pend_set_en   (pend_set_en),
    .pend_set_addr (pend_set_addr),
    .pend_cnt      (cnt_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] we,
                               input logic [4:0] wa0, input logic [31:0] wd0,
                               input logic [4:0] wa1, input logic [31:0] wd1,
                               input logic ps, input logic [4:0] pa,
                               input logic [4:0] ra0, input logic [4:0] ra1);
    @(posedge clk);
    #1;
    wr_en         = we;
    wr_addr       = {wa1, wa0};
    wr_data       = {wd1, wd0};
    pend_set_en   = ps;
    pend_set_addr = pa;
    rd_addr       = {ra1, ra0};
  endtask

  // Architectural state update: r0 is never written or marked, the later
  // port overwrites the earlier one, writes retire pending state and a set
  // in the same cycle re-marks the register.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  = 32'd0;
        m_pend[i] = 1'b0;
      end
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (wr_en[j] && wr_addr[j*5 +: 5] != 5'd0) begin
          m_mem[wr_addr[j*5 +: 5]]  = wr_data[j*32 +: 32];
          m_pend[wr_addr[j*5 +: 5]] = 1'b0;
        end
      end
      if (pend_set_en && pend_set_addr != 5'd0) m_pend[pend_set_addr] = 1'b1;
    end
  end

  function automatic logic [31:0] expData(input int p, input bit byp);
    logic [4:0]  a;
    logic [31:0] d;
    a = rd_addr[p*5 +: 5];
    if (!rst_n || a == 5'd0) return 32'd0;
    d = m_mem[a];
    if (byp) begin
      for (int j = 0; j < 2; j++)
        if (wr_en[j] && wr_addr[j*5 +: 5] == a) d = wr_data[j*32 +: 32];
    end
    return d;
  endfunction

  function automatic logic [31:0] expPend(input int p, input bit byp);
    logic [4:0] a;
    bit         pb;
    a = rd_addr[p*5 +: 5];
    if (!rst_n || a == 5'd0) return 32'd0;
    pb = m_pend[a];
    if (byp) begin
      for (int j = 0; j < 2; j++)
        if (wr_en[j] && wr_addr[j*5 +: 5] == a) pb = 1'b0;
    end
    return {31'd0, pb};
  endfunction

  function automatic logic [31:0] expCnt();
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) if (m_pend[i]) n++;
    return 32'(n);
  endfunction

  // Continuous comparison of both instances against the model.
  always @(negedge clk) begin
    if (check_en) begin
      for (int p = 0; p < 2; p++) begin
        checkOutput($sformatf("byp.rd_data%0d", p),    rd_data_b[p*32 +: 32], expData(p, 1'b1));
        checkOutput($sformatf("nobyp.rd_data%0d", p),  rd_data_n[p*32 +: 32], expData(p, 1'b0));
        checkOutput($sformatf("byp.rd_pending%0d", p), 32'(rd_pend_b[p]),     expPend(p, 1'b1));
        checkOutput($sformatf("nobyp.rd_pending%0d", p), 32'(rd_pend_n[p]),   expPend(p, 1'b0));
      end
      checkOutput("byp.pend_cnt",   32'(cnt_b), expCnt());
      checkOutput("nobyp.pend_cnt", 32'(cnt_n), expCnt());
    end
  end

  initial begin
    checks        = 0;
    errors        = 0;
    check_en      = 1'b0;
    rst_n         = 1'b0;
    rd_addr       = '0;
    wr_en         = '0;
    wr_addr       = '0;
    wr_data       = '0;
    pend_set_en   = 1'b0;
    pend_set_addr = '0;

    repeat (2) @(posedge clk);
    #1;
    check_en = 1'b1;
    @(negedge clk);
    checkOutput("reset.rd_data",    rd_data_b[31:0], 32'd0);
    checkOutput("reset.rd_pending", 32'(rd_pend_b),  32'd0);
    checkOutput("reset.pend_cnt",   32'(cnt_b),      32'd0);

    pc_vec = '0;
    pc_vec[7:0] = 8'hF0;
    pc_vec[100] = 1'b1;
    checkOutput("rf_popcount", rf_popcount(pc_vec), 32'd5);

    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset discards state and an in-flight write.
    applyStimulus(2'b01, 5'd5, 32'h1234, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5, 5'd5);
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd5);
    @(negedge clk);
    checkOutput("r5.after_write", rd_data_b[31:0], 32'h1234);
    checkOutput("r5.pending",     32'(rd_pend_b[0]), 32'd1);
    checkOutput("r5.pend_cnt",    32'(cnt_b), 32'd1);
    @(posedge clk);
    #2;
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd5};
    wr_data = {32'd0, 32'hBEEF};
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset.byp.rd_data",   rd_data_b[31:0], 32'd0);
    checkOutput("midreset.nobyp.rd_data", rd_data_n[31:0], 32'd0);
    checkOutput("midreset.rd_pending",    32'(rd_pend_b), 32'd0);
    checkOutput("midreset.pend_cnt",      32'(cnt_b), 32'd0);
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd5);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midreset.write_discarded", rd_data_b[31:0], 32'd0);

    // Register 0 stays zero and never pending.
    applyStimulus(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    checkOutput("r0.bypass_read", rd_data_b[31:0], 32'd0);
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    checkOutput("r0.read",     rd_data_n[31:0], 32'd0);
    checkOutput("r0.pend_cnt", 32'(cnt_b), 32'd0);

    // Same-address collision: port 1 wins.
    applyStimulus(2'b11, 5'd7, 32'hAAAA0000, 5'd7, 32'h5555FFFF, 1'b0, 5'd0, 5'd7, 5'd7);
    @(negedge clk);
    checkOutput("r7.bypass_priority", rd_data_b[31:0], 32'h5555FFFF);
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd7);
    @(negedge clk);
    checkOutput("r7.priority.byp",   rd_data_b[63:32], 32'h5555FFFF);
    checkOutput("r7.priority.nobyp", rd_data_n[31:0],  32'h5555FFFF);

    // Forwarding versus stored value.
    applyStimulus(2'b01, 5'd9, 32'h11, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd9);
    applyStimulus(2'b01, 5'd9, 32'h22, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd9);
    @(negedge clk);
    checkOutput("r9.byp.same_cycle",   rd_data_b[63:32], 32'h22);
    checkOutput("r9.nobyp.same_cycle", rd_data_n[63:32], 32'h11);
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd9);
    @(negedge clk);
    checkOutput("r9.nobyp.after_edge", rd_data_n[63:32], 32'h22);

    // Scoreboard.
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd4);
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd3, 5'd4);
    @(negedge clk);
    checkOutput("sb.r3_pending", 32'(rd_pend_b[0]), 32'd1);
    checkOutput("sb.cnt1",       32'(cnt_b), 32'd1);
    applyStimulus(2'b01, 5'd3, 32'h33, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd4);
    @(negedge clk);
    checkOutput("sb.cnt2",             32'(cnt_b), 32'd2);
    checkOutput("sb.r3.byp_cleared",   32'(rd_pend_b[0]), 32'd0);
    checkOutput("sb.r3.nobyp_pending", 32'(rd_pend_n[0]), 32'd1);
    applyStimulus(2'b01, 5'd4, 32'h99, 5'd0, 32'd0, 1'b1, 5'd4, 5'd3, 5'd4);
    @(negedge clk);
    checkOutput("sb.cnt_after_r3_write", 32'(cnt_n), 32'd1);
    checkOutput("sb.r3_cleared",         32'(rd_pend_n[0]), 32'd0);
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd4);
    @(negedge clk);
    checkOutput("sb.r4_set_wins",  32'(rd_pend_b[1]), 32'd1);
    checkOutput("sb.r4_data",      rd_data_b[63:32], 32'h99);
    checkOutput("sb.cnt_final",    32'(cnt_b), 32'd1);

    // Randomized traffic with addresses biased toward a small set so that
    // collisions, r0 accesses and set/write overlaps occur often.
    for (int c = 0; c < 10000; c++) begin
      logic [4:0] a [5];
      for (int k = 0; k < 5; k++)
        a[k] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      applyStimulus(2'($urandom), a[0], $urandom, a[1], $urandom,
                    ($urandom_range(0, 2) == 0), a[2], a[3], a[4]);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
    end

    @(posedge clk);
    #1;
    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port general-purpose register file for the MIPS datapath. It is the successor to the single-write, dual-read register file. It adds:
- configurable width, depth and port counts
- deterministic write-port priority
- optional same-cycle write-to-read bypass
- asynchronous clear
- a per-register pending scoreboard, so decode can detect load-use and long-latency hazards

It sits between decode (reads, scoreboard set) and writeback (writes).

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 32, number of architectural registers; register 0 is hard-wired to zero
ADDR_W, $clog2(NUM_REGS), register address width
NUM_RD, 2, number of combinational read ports (1..4)
NUM_WR, 2, number of write ports (1..2)
BYPASS, 1, 1 = a same-cycle write is visible on read data; 0 = read data returns the stored value

Ports:
clk  in  1  system clock, rising-edge active
rst_n  in  1  asynchronous active-low reset
rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data, port i at bits [i*DATA_W +: DATA_W]
rd_pending  out  NUM_RD  1 = register addressed by read port i awaits a write
wr_en  in  NUM_WR  write enable per write port
wr_addr  in  NUM_WR*ADDR_W  write addresses
wr_data  in  NUM_WR*DATA_W  write data
pend_set_en  in  1  mark a register as pending (instruction issued with a long-latency destination)
pend_set_addr  in  ADDR_W  register to mark
pend_cnt  out  ADDR_W+1  number of registers currently pending

Behaviour:
Reset:
- rst_n low clears every register to 0 and every pending bit to 0, asynchronously.
- Outputs during reset: rd_data all 0, rd_pending 0, pend_cnt 0.
- Reset asserted mid-write discards that write.

Writes:
- A write commits on the rising clk edge when wr_en[j]=1 and wr_addr[j]!=0.
- A write to address 0 is ignored.
- Two write ports with the same address in one cycle: the higher-index port wins.
- Addresses >= NUM_REGS are ignored for writes, and read as 0.

Reads:
- Reads are combinational, zero latency.
- rd_addr=0 always returns 0.
- BYPASS=1: if any enabled write port targets the same nonzero address in the current cycle, rd_data returns that port's wr_data. When several ports match, the highest index wins. Otherwise rd_data returns the stored value.
- BYPASS=0: rd_data always returns the stored value, i.e. the pre-edge value.

Scoreboard:
- A pending bit is set at the clk edge when pend_set_en=1 and pend_set_addr!=0.
- A pending bit is cleared at the clk edge by any committed write to that address.
- Set and write to the same address in the same cycle: set wins and the bit stays 1, because a newer producer has been issued. The data write still commits.
- Setting an already-pending bit leaves it at 1.
- rd_pending[i] = pending[rd_addr[i]], forced to 0 when rd_addr[i]=0. With BYPASS=1 it is also 0 when a same-cycle write clears that register.
- pend_cnt is the registered population count of the pending bits. It is updated at the same edge as the bits, so it is 1-cycle aligned with the pending state. Its range is 0..NUM_REGS-1.

Structure:
- No state machine.
- Sequential state consists of the register array, the pending vector and pend_cnt.
- Simulation-only display of register contents is optional, gated by `ifdef RF_TRACE`. It is not part of RTL behaviour.

Decomposition:
- Shared package rf_pkg holds:
  - the default constants DATA_W_DEF=32, NUM_REGS_DEF=32 and REG_ZERO=0
  - a function rf_popcount used for pend_cnt and by the bench
- Natural sub-module: rf_bypass_mux, one per read port.
  - Inputs: the read address, the stored value and all write ports.
  - Outputs: the forwarded data and the hit flag.
  - Contains the highest-index priority logic.
  - The top instantiates it NUM_RD times in a generate loop.

Test Plan:
1. Reset: write 0x1234 to r5, assert rst_n low between edges -> rd_data for r5 reads 0 immediately; rd_pending=0; pend_cnt=0.
2. Zero register: wr_en[0]=1, wr_addr=0, wr_data=0xFFFFFFFF -> reading r0 returns 0 and r0's pending bit never sets.
3. Write priority: port0 writes r7=0xAAAA0000 and port1 writes r7=0x5555FFFF in the same cycle -> next cycle r7 reads 0x5555FFFF.
4. Bypass: BYPASS=1, r9=0x11; same cycle port0 writes r9=0x22 while rd_addr[1]=9 -> rd_data[1]=0x22 before the edge. With BYPASS=0 the same stimulus gives 0x11, then 0x22 after the edge.
5. Scoreboard: pend_set r3 -> rd_pending=1, pend_cnt=1. Set r4 -> pend_cnt=2. Write r3 -> r3 clears, pend_cnt=1. In one cycle, pend_set r4 plus a write to r4=0x99 -> r4 still pending, r4 data=0x99.
6. Random: 10k cycles of random reads, writes and sets against a reference model -> rd_data, rd_pending and pend_cnt all match; includes reset asserted mid-run.
